// File: rtl/lcd_rx_pkg.sv
// Shared definitions for the LCD receive-side timing monitor.
//   - lcd_rx_state_e : lock FSM states (SEARCH, MEASURE, LOCKED)
//   - DEF_*          : default 480x272 panel geometry
//   - BAR_COUNT      : number of vertical colour bars in the test pattern
//   - RGB_W          : width of the packed {r,g,b} pixel word
package lcd_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } lcd_rx_state_e;

    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_H_TOTAL  = 525;
    localparam int DEF_V_TOTAL  = 286;

    localparam int BAR_COUNT = 8;
    // One bar index per colour combination, so the pixel word is log2 of the bar count.
    localparam int RGB_W     = $clog2(BAR_COUNT);

endpackage

// File: rtl/lcd_rx_edge.sv
// Input capture and falling-edge detection for the LCD receive monitor.
// Every pin is registered once (_p0); VS/HS/DE are delayed once more (_p1)
// and compared with the _p0 copy to produce single-cycle fall strobes.
// Ports:
//   clk                         pixel clock
//   lcd_vs/lcd_hs/lcd_de        raw sync / enable pins
//   lcd_r/lcd_g/lcd_b           raw colour pins
//   vs_fall/hs_fall/de_fall     one-cycle falling-edge strobes
//   de_p0                       registered DE level
//   rgb_p0                      registered {r,g,b}
module lcd_rx_edge
    import lcd_rx_pkg::*;
(
    input  logic             clk,
    input  logic             lcd_vs,
    input  logic             lcd_hs,
    input  logic             lcd_de,
    input  logic             lcd_r,
    input  logic             lcd_g,
    input  logic             lcd_b,
    output logic             vs_fall,
    output logic             hs_fall,
    output logic             de_fall,
    output logic             de_p0,
    output logic [RGB_W-1:0] rgb_p0
);

    logic vs_p0;
    logic hs_p0;
    logic vs_p1;
    logic hs_p1;
    logic de_p1;

    // Stage p0: pin capture; stage p1: delayed copy for edge comparison
    always_ff @(posedge clk) begin
        vs_p0  <= lcd_vs;
        hs_p0  <= lcd_hs;
        de_p0  <= lcd_de;
        rgb_p0 <= {lcd_r, lcd_g, lcd_b};
        vs_p1  <= vs_p0;
        hs_p1  <= hs_p0;
        de_p1  <= de_p0;
    end

    assign vs_fall = vs_p1 & ~vs_p0;
    assign hs_fall = hs_p1 & ~hs_p0;
    assign de_fall = de_p1 & ~de_p0;

endmodule

// File: rtl/lcd_rx_monitor.sv
// Receive-side checker for the parallel RGB LCD timing interface.
// Measures line length, active width, lines per frame and active lines per
// frame, compares them with the expected geometry and asserts o_locked after
// LOCK_FRAMES consecutive conforming frames.
// Optional feature: define LCD_RX_PATTERN_CHECK_EN to check the 8 colour bars
// and count mismatching pixels in o_pix_err_cnt (tied to 0 otherwise).
// Ports:
//   i_clk, i_reset                 pixel clock, synchronous active-high reset
//   i_lcd_vs/hs/de, i_lcd_r/g/b     monitored LCD pins
//   o_locked                        geometry has matched for LOCK_FRAMES frames
//   o_err                           one-cycle pulse per bad frame or timeout
//   o_h_total/o_h_active            last line period / last DE run length
//   o_v_total/o_v_active            last frame line count / active line count
//   o_frame_cnt                     frames evaluated (wraps)
//   o_pix_err_cnt                   colour bar mismatches (saturating)
module lcd_rx_monitor
    import lcd_rx_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 12
)
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_lcd_vs,
    input  logic             i_lcd_hs,
    input  logic             i_lcd_de,
    input  logic             i_lcd_r,
    input  logic             i_lcd_g,
    input  logic             i_lcd_b,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_h_total,
    output logic [CNT_W-1:0] o_h_active,
    output logic [CNT_W-1:0] o_v_total,
    output logic [CNT_W-1:0] o_v_active,
    output logic [15:0]      o_frame_cnt,
    output logic [15:0]      o_pix_err_cnt
);

    localparam logic [CNT_W-1:0] H_ACTIVE_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACTIVE_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_TOTAL_C  = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] V_TOTAL_C  = CNT_W'(V_TOTAL);
    localparam logic [4:0]       LOCK_C     = 5'(LOCK_FRAMES);

    logic             vs_fall;
    logic             hs_fall;
    logic             de_fall;
    logic             de_p0;
    logic [RGB_W-1:0] rgb_p0;

    lcd_rx_edge u_edge (
        .clk     (i_clk),
        .lcd_vs  (i_lcd_vs),
        .lcd_hs  (i_lcd_hs),
        .lcd_de  (i_lcd_de),
        .lcd_r   (i_lcd_r),
        .lcd_g   (i_lcd_g),
        .lcd_b   (i_lcd_b),
        .vs_fall (vs_fall),
        .hs_fall (hs_fall),
        .de_fall (de_fall),
        .de_p0   (de_p0),
        .rgb_p0  (rgb_p0)
    );

    lcd_rx_state_e    state_q;
    lcd_rx_state_e    state_d;
    logic [3:0]       good_cnt_q;
    logic [3:0]       good_cnt_d;
    logic             err_d;
    logic             frame_inc;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] decnt_q;
    logic [CNT_W-1:0] vcnt_tot_q;
    logic [CNT_W-1:0] vcnt_act_q;
    logic             frame_bad_q;
    logic             pix_bad;

    logic             timeout;
    logic             line_bad;
    logic [CNT_W-1:0] h_total_now;
    logic [CNT_W-1:0] vtot_now;
    logic [CNT_W-1:0] vact_now;
    logic             frame_good;

    // Stage p1: measurements that include events landing on the closing VS fall
    assign timeout     = (&hcnt_q) && (state_q != SEARCH);
    assign line_bad    = de_fall && (decnt_q != H_ACTIVE_C);
    assign h_total_now = hs_fall ? hcnt_q + CNT_W'(1) : o_h_total;
    assign vtot_now    = vcnt_tot_q + CNT_W'(hs_fall);
    assign vact_now    = vcnt_act_q + CNT_W'(de_fall);
    assign frame_good  = (h_total_now == H_TOTAL_C) && (vact_now == V_ACTIVE_C) &&
                         (vtot_now == V_TOTAL_C) && !frame_bad_q && !line_bad && !pix_bad;

    assign o_locked = (state_q == LOCKED);

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_d      = 1'b0;
        frame_inc  = 1'b0;
        if (timeout) begin
            state_d    = SEARCH;
            good_cnt_d = '0;
            err_d      = 1'b1;
        end else if (vs_fall) begin
            if (state_q == SEARCH) begin
                // First VS fall only aligns to the frame; nothing measured yet.
                state_d = MEASURE;
            end else begin
                frame_inc = 1'b1;
                if (frame_good) begin
                    if ({1'b0, good_cnt_q} < LOCK_C) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                    end
                    if ({1'b0, good_cnt_q} + 5'd1 >= LOCK_C) begin
                        state_d = LOCKED;
                    end
                end else begin
                    state_d    = MEASURE;
                    good_cnt_d = '0;
                    err_d      = 1'b1;
                end
            end
        end
    end

    // Stage p2: registered FSM, counters and measurement outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= SEARCH;
            good_cnt_q  <= '0;
            o_err       <= 1'b0;
            o_frame_cnt <= '0;
            o_h_total   <= '0;
            o_h_active  <= '0;
            o_v_total   <= '0;
            o_v_active  <= '0;
            hcnt_q      <= '0;
            decnt_q     <= '0;
            vcnt_tot_q  <= '0;
            vcnt_act_q  <= '0;
            frame_bad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            o_err      <= err_d;
            if (frame_inc) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end

            if (hs_fall) begin
                o_h_total <= hcnt_q + CNT_W'(1);
                hcnt_q    <= '0;
            end else if (!(&hcnt_q)) begin
                hcnt_q <= hcnt_q + CNT_W'(1);
            end

            if (de_fall) begin
                o_h_active <= decnt_q;
            end

            if (timeout) begin
                decnt_q <= '0;
            end else if (de_fall) begin
                decnt_q <= '0;
            end else if (de_p0) begin
                decnt_q <= decnt_q + CNT_W'(1);
            end

            if (vs_fall) begin
                o_v_total <= vtot_now;
                o_v_active <= vact_now;
            end

            if (vs_fall || timeout) begin
                vcnt_tot_q  <= '0;
                vcnt_act_q  <= '0;
                frame_bad_q <= 1'b0;
            end else begin
                vcnt_tot_q <= vtot_now;
                vcnt_act_q <= vact_now;
                if (line_bad || pix_bad) begin
                    frame_bad_q <= 1'b1;
                end
            end
        end
    end

`ifdef LCD_RX_PATTERN_CHECK_EN
    localparam int               BAR_LEN   = H_ACTIVE / BAR_COUNT;
    localparam logic [CNT_W-1:0] BAR_END_C = CNT_W'(BAR_LEN - 1);

    logic [CNT_W-1:0] bar_pix_q;
    logic [RGB_W-1:0] bar_q;
    logic [15:0]      pix_err_cnt_q;

    // Bar 0 is white, bar 7 black: the expected colour is the inverted bar index.
    assign pix_bad       = de_p0 && (rgb_p0 != ~bar_q);
    assign o_pix_err_cnt = pix_err_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bar_pix_q     <= '0;
            bar_q         <= '0;
            pix_err_cnt_q <= '0;
        end else begin
            if (!de_p0) begin
                bar_pix_q <= '0;
                bar_q     <= '0;
            end else if (bar_pix_q == BAR_END_C) begin
                bar_pix_q <= '0;
                bar_q     <= bar_q + RGB_W'(1);
            end else begin
                bar_pix_q <= bar_pix_q + CNT_W'(1);
            end
            if (pix_bad && (pix_err_cnt_q != 16'hFFFF)) begin
                pix_err_cnt_q <= pix_err_cnt_q + 16'd1;
            end
        end
    end
`else
    logic unused_rgb;

    assign unused_rgb    = ^rgb_p0;
    assign pix_bad       = 1'b0;
    assign o_pix_err_cnt = '0;
`endif

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Bench for lcd_rx_monitor: a small-geometry LCD generator drives frames with
// selectable faults; a frame-level model predicts lock, errors and counts.
module tb_lcd_rx_monitor;

    localparam int H_ACTIVE    = 16;
    localparam int V_ACTIVE    = 6;
    localparam int H_TOTAL     = 24;
    localparam int V_TOTAL     = 9;
    localparam int LOCK_FRAMES = 2;
    localparam int CNT_W       = 12;
    localparam int HS_W        = 2;
    localparam int DE_START    = 4;
    localparam int VS_LINES    = 2;
    localparam int V_START     = 2;
    localparam int BAR_LEN     = H_ACTIVE / 8;
`ifdef LCD_RX_PATTERN_CHECK_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic vs = 1'b1;
    logic hs = 1'b1;
    logic de = 1'b0;
    logic r = 1'b0;
    logic g = 1'b0;
    logic b = 1'b0;

    logic             o_locked;
    logic             o_err;
    logic [CNT_W-1:0] o_h_total;
    logic [CNT_W-1:0] o_h_active;
    logic [CNT_W-1:0] o_v_total;
    logic [CNT_W-1:0] o_v_active;
    logic [15:0]      o_frame_cnt;
    logic [15:0]      o_pix_err_cnt;

    lcd_rx_monitor #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_TOTAL     (H_TOTAL),
        .V_TOTAL     (V_TOTAL),
        .LOCK_FRAMES (LOCK_FRAMES),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_lcd_vs      (vs),
        .i_lcd_hs      (hs),
        .i_lcd_de      (de),
        .i_lcd_r       (r),
        .i_lcd_g       (g),
        .i_lcd_b       (b),
        .o_locked      (o_locked),
        .o_err         (o_err),
        .o_h_total     (o_h_total),
        .o_h_active    (o_h_active),
        .o_v_total     (o_v_total),
        .o_v_active    (o_v_active),
        .o_frame_cnt   (o_frame_cnt),
        .o_pix_err_cnt (o_pix_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int err_seen = 0;

    always @(posedge clk) begin
        if (o_err === 1'b1) err_seen <= err_seen + 1;
    end

    // Frame-level reference model
    bit m_synced = 1'b0;
    int m_run = 0;
    bit m_locked = 1'b0;
    int m_frames = 0;
    int m_errs = 0;
    int m_pix = 0;
    int prev_vtot = 0;
    int prev_short = -1;
    int prev_black = -1;
    bit prev_full = 1'b0;

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        vs = 1'b1;
        hs = 1'b1;
        de = 1'b0;
    endtask

    task automatic gen_frame(input int vtot, input int short_line, input int black_line,
                             input int stop_line);
        bit evald;
        bit good;
        int len;
        int p;
        logic [2:0] bv;
        evald = 1'b0;
        if (!m_synced) begin
            m_synced = 1'b1;
        end else begin
            evald = 1'b1;
            m_frames++;
            good = prev_full && (prev_vtot == V_TOTAL) && (prev_short < 0) &&
                   !(PAT_EN && (prev_black >= 0));
            if (good) begin
                m_run++;
                if (m_run >= LOCK_FRAMES) m_locked = 1'b1;
            end else begin
                m_run = 0;
                m_locked = 1'b0;
                m_errs++;
            end
        end
        for (int l = 0; l < stop_line; l++) begin
            for (int c = 0; c < H_TOTAL; c++) begin
                @(posedge clk);
                #1;
                vs = (l >= VS_LINES);
                hs = (c >= HS_W);
                len = (l == short_line) ? H_ACTIVE - 1 : H_ACTIVE;
                de = (l >= V_START) && (l < V_START + V_ACTIVE) &&
                     (c >= DE_START) && (c < DE_START + len);
                if (de) begin
                    p = c - DE_START;
                    bv = 3'(p / BAR_LEN);
                    {r, g, b} = ~bv;
                    if ((l == black_line) && (p == 0)) {r, g, b} = 3'b000;
                end else begin
                    {r, g, b} = 3'($urandom_range(0, 7));
                end
                if ((c == 0) && (l > V_START) && (l <= V_START + V_ACTIVE)) begin
                    checks++;
                    if (o_h_active !== CNT_W'((l - 1 == short_line) ? H_ACTIVE - 1 : H_ACTIVE)) begin
                        failures++;
                        $display("FAIL h_active line %0d: got %0d expected %0d", l - 1, o_h_active,
                                 (l - 1 == short_line) ? H_ACTIVE - 1 : H_ACTIVE);
                    end
                end
                if ((l == 0) && (c == 6)) begin
                    checks++;
                    if (o_frame_cnt !== 16'(m_frames)) begin
                        failures++;
                        $display("FAIL frame_cnt: got %0d expected %0d", o_frame_cnt, m_frames);
                    end
                    checks++;
                    if (o_locked !== m_locked) begin
                        failures++;
                        $display("FAIL locked at frame %0d: got %0b expected %0b", m_frames, o_locked, m_locked);
                    end
                    checks++;
                    if (err_seen !== m_errs) begin
                        failures++;
                        $display("FAIL err pulses: got %0d expected %0d", err_seen, m_errs);
                    end
                    checks++;
                    if (o_pix_err_cnt !== 16'(m_pix)) begin
                        failures++;
                        $display("FAIL pix_err_cnt: got %0d expected %0d", o_pix_err_cnt, m_pix);
                    end
                    if (evald) begin
                        checks++;
                        if (o_v_total !== CNT_W'(prev_vtot)) begin
                            failures++;
                            $display("FAIL v_total: got %0d expected %0d", o_v_total, prev_vtot);
                        end
                        checks++;
                        if (o_v_active !== CNT_W'(V_ACTIVE)) begin
                            failures++;
                            $display("FAIL v_active: got %0d expected %0d", o_v_active, V_ACTIVE);
                        end
                        checks++;
                        if (o_h_total !== CNT_W'(H_TOTAL)) begin
                            failures++;
                            $display("FAIL h_total: got %0d expected %0d", o_h_total, H_TOTAL);
                        end
                    end
                end
            end
        end
        if (PAT_EN && (black_line >= V_START) && (black_line < V_START + V_ACTIVE) &&
            (black_line < stop_line)) begin
            m_pix++;
        end
        prev_vtot  = vtot;
        prev_short = short_line;
        prev_black = black_line;
        prev_full  = (stop_line == vtot);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({o_locked, o_err} !== 2'b00) begin
            failures++;
            $display("FAIL %s locked/err: got %b expected 00", tag, {o_locked, o_err});
        end
        checks++;
        if ({o_h_total, o_h_active, o_v_total, o_v_active} !== '0) begin
            failures++;
            $display("FAIL %s measurements: got %0d/%0d/%0d/%0d expected 0", tag,
                     o_h_total, o_h_active, o_v_total, o_v_active);
        end
        checks++;
        if ({o_frame_cnt, o_pix_err_cnt} !== 32'd0) begin
            failures++;
            $display("FAIL %s counters: got %0d/%0d expected 0", tag, o_frame_cnt, o_pix_err_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) idle_cycle();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (3) idle_cycle();
    endtask

    task automatic test_nominal();
        repeat (4) gen_frame(V_TOTAL, -1, -1, V_TOTAL);
        checks++;
        if (o_locked !== 1'b1) begin
            failures++;
            $display("FAIL nominal lock: got %0b expected 1", o_locked);
        end
    endtask

    task automatic test_short_line();
        gen_frame(V_TOTAL, V_START + int'($urandom_range(0, V_ACTIVE - 1)), -1, V_TOTAL);
        repeat (3) gen_frame(V_TOTAL, -1, -1, V_TOTAL);
    endtask

    task automatic test_timeout();
        int frames_before;
        frames_before = m_frames;
        repeat (4200) idle_cycle();
        m_errs++;
        m_synced = 1'b0;
        m_run = 0;
        m_locked = 1'b0;
        checks++;
        if (err_seen !== m_errs) begin
            failures++;
            $display("FAIL timeout err: got %0d expected %0d", err_seen, m_errs);
        end
        checks++;
        if (o_locked !== 1'b0) begin
            failures++;
            $display("FAIL timeout locked: got %0b expected 0", o_locked);
        end
        checks++;
        if (o_frame_cnt !== 16'(frames_before)) begin
            failures++;
            $display("FAIL timeout frame_cnt: got %0d expected %0d", o_frame_cnt, frames_before);
        end
        repeat (3) gen_frame(V_TOTAL, -1, -1, V_TOTAL);
    endtask

    task automatic test_vtotal();
        repeat (4) gen_frame(V_TOTAL + 1, -1, -1, V_TOTAL + 1);
        repeat (3) gen_frame(V_TOTAL, -1, -1, V_TOTAL);
    endtask

    task automatic test_pattern();
        gen_frame(V_TOTAL, -1, V_START + 1, V_TOTAL);
        repeat (3) gen_frame(V_TOTAL, -1, -1, V_TOTAL);
    endtask

    task automatic test_random();
        int vt;
        int sl;
        int bl;
        for (int i = 0; i < 12; i++) begin
            vt = ($urandom_range(0, 5) == 0) ? V_TOTAL + 1 : V_TOTAL;
            sl = ($urandom_range(0, 4) == 0) ? V_START + int'($urandom_range(0, V_ACTIVE - 1)) : -1;
            bl = ($urandom_range(0, 4) == 0) ? V_START + int'($urandom_range(0, V_ACTIVE - 1)) : -1;
            gen_frame(vt, sl, bl, vt);
        end
    endtask

    task automatic test_reset_mid_frame();
        repeat (3) gen_frame(V_TOTAL, -1, -1, V_TOTAL);
        gen_frame(V_TOTAL, -1, -1, 4);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("mid_reset");
        reset = 1'b0;
        m_synced = 1'b0;
        m_run = 0;
        m_locked = 1'b0;
        m_frames = 0;
        m_pix = 0;
        repeat (3) gen_frame(V_TOTAL, -1, -1, V_TOTAL);
        checks++;
        if (o_locked !== 1'b1) begin
            failures++;
            $display("FAIL relock after reset: got %0b expected 1", o_locked);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_line();
        test_timeout();
        test_vtotal();
        test_pattern();
        test_random();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
